pipelined_barrel_shifter: RTL and testbench
===========================================

Name: pipelined_barrel_shifter

Overview:
Parametrised, pipelined successor to the combinational 32-bit right shifter. It supports four operations (logical left, logical right, arithmetic right, rotate right) at any power-of-two width. One register stage per power-of-two shift layer, with valid/ready handshakes at both ends and full backpressure. It sits between the ALU operand latches and the writeback mux in the execute path, and carries an opaque tag per operation.

Parameters:
WIDTH, 32, data width; power of two, >= 2
TAG_W, 4, width of the opaque tag carried alongside each operation; >= 1
AW, $clog2(WIDTH), shift-amount width (derived; must not be overridden)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous; kills all in-flight operations
in_valid  in  1  input operation present
in_ready  out  1  block accepts input this cycle
in_data  in  WIDTH  operand
in_amount  in  AW  shift distance, 0..WIDTH-1
in_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR
in_tag  in  TAG_W  passed through unchanged
out_valid  out  1  result present
out_ready  in  1  consumer accepts result
out_data  out  WIDTH  shifted result
out_tag  out  TAG_W  tag of the result

Behaviour:
- Pipeline of AW stages, indexed k = 0..AW-1. Each stage register holds valid_k, data, remaining amount bits, op and tag.
- Stage k applies a shift of 2^k when amount bit k is set; otherwise it passes data through.
- Output ports are driven directly from stage AW-1 registers.
- Latency: exactly AW cycles from an accepted input to out_valid when there is no backpressure (5 for WIDTH=32). Throughput is 1 op/cycle.
- Shift rules:
  - SRL fills vacated MSBs with 0.
  - SRA fills vacated MSBs with the original in_data[WIDTH-1]. The sign is captured at stage 0 and carried forward.
  - ROR wraps shifted-out LSBs into the MSBs.
  - SLL fills vacated LSBs with 0. It is implemented as bit-reverse, SRL, bit-reverse, or with equivalent logic.
  - Amount 0 returns in_data unchanged for all ops.
- Per-stage flow control:
  - advance_last = !valid_last || out_ready.
  - Stage k (k < AW-1) loads from stage k-1, or from the input for k=0, when !valid_k || advance_{k+1}. Bubbles collapse.
  - A stage that does not load holds all of its fields.
  - in_ready = !valid_0 || advance_1. For AW=1, in_ready = advance_last.
  - Input accepted iff in_valid && in_ready. A stage whose source is invalid loads valid=0.
- out_valid/out_data/out_tag stay stable while out_valid && !out_ready.
- No combinational path from in_valid or in_data to the outputs. in_ready depends combinationally on out_ready only through the advance chain.
- flush:
  - Clears every valid_k on the next edge.
  - An input presented in the same cycle is discarded, and in_ready is forced 0 during flush.
  - Data fields may retain stale values.
- Reset (rst_n=0, any time, including mid-operation):
  - Immediately clears all valid_k, data, amount, op and tag registers to 0.
  - Consequently out_valid=0, out_data=0, out_tag=0. in_ready is 1 once rst_n deasserts and flush is low.
- Simultaneous events:
  - flush overrides out_ready and in_valid.
  - When the pipeline is full and out_ready=1, a new input is accepted in the same cycle as the output retires.

Test Plan:
1. WIDTH=32. Send SLL 0x0000_0001 amt 31, SRL 0x8000_0000 amt 31, SRA 0x8000_0000 amt 4, ROR 0x1234_5678 amt 8 on consecutive cycles, with out_ready=1. Required: results 0x8000_0000, 0x0000_0001, 0xF800_0000, 0x7812_3456 on cycles 5, 6, 7, 8 after the first accept, with tags in order.
2. All four ops with amount 0 on 0xDEAD_BEEF -> all results 0xDEAD_BEEF. Also SRA 0x7FFF_FFFF amt 31 -> 0x0000_0000.
3. Backpressure:
   - Stream 8 ops while holding out_ready=0. Required: in_ready drops after exactly 5 accepts, and out_data/out_tag stay stable.
   - Then raise out_ready for 1 cycle. Required: one result retires and one new op is accepted in that same cycle.
4. Bubbles: insert in_valid gaps and random out_ready. Required: a scoreboard sees every result in order, with no duplicates and no drops.
5. Assert flush with 3 ops in flight and in_valid=1. Required: next cycle out_valid=0; the flushed ops and the concurrent input never appear; a new op issued afterwards completes in 5 cycles.
6. Pulse rst_n low mid-stream (asynchronously, between edges). Required: out_valid and out_data go to 0 immediately, no pre-reset result ever emerges, and in_ready=1 after release.

Source files
------------

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: SLL/SRL/SRA/ROR with one register stage per power-of-two
// shift layer, valid/ready handshakes at both ends and an opaque tag per operation.
module pipelined_barrel_shifter #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AW-1:0]    in_amount,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = d[WIDTH-1-i];
        return r;
    endfunction

    // Right shift by 2^k; fill depends on op (SLL arrives bit-reversed, so zero fill).
    function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                    input logic [1:0] op,
                                                    input logic sign,
                                                    input int k);
        logic [WIDTH-1:0] r;
        int s;
        s = 1 << k;
        for (int i = 0; i < WIDTH; i++) begin
            if (i + s < WIDTH)   r[i] = d[i+s];
            else if (op == OP_ROR) r[i] = d[i+s-WIDTH];
            else if (op == OP_SRA) r[i] = sign;
            else                 r[i] = 1'b0;
        end
        return r;
    endfunction

    logic [AW-1:0]    stage_valid;
    logic [WIDTH-1:0] stage_data   [AW];
    logic [AW-1:0]    stage_amount [AW];
    logic [1:0]       stage_op     [AW];
    logic [TAG_W-1:0] stage_tag    [AW];
    logic             stage_sign   [AW];

    logic [AW-1:0]    load;
    logic             accept;
    logic [AW-1:0]    src_valid;
    logic [WIDTH-1:0] src_data   [AW];
    logic [AW-1:0]    src_amount [AW];
    logic [1:0]       src_op     [AW];
    logic [TAG_W-1:0] src_tag    [AW];
    logic             src_sign   [AW];
    logic [WIDTH-1:0] next_data  [AW];

    // A stage loads when it is empty or its successor is loading, so bubbles collapse.
    always_comb begin
        logic chain;
        chain = !stage_valid[AW-1] || out_ready;
        load  = '0;
        load[AW-1] = chain;
        for (int k = AW - 2; k >= 0; k--) begin
            chain   = !stage_valid[k] || chain;
            load[k] = chain;
        end
    end

    assign in_ready = load[0] && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        src_valid     = '0;
        src_valid[0]  = accept;
        src_data[0]   = (in_op == OP_SLL) ? bit_reverse(in_data) : in_data;
        src_amount[0] = in_amount;
        src_op[0]     = in_op;
        src_tag[0]    = in_tag;
        src_sign[0]   = in_data[WIDTH-1];
        for (int k = 1; k < AW; k++) begin
            src_valid[k]  = stage_valid[k-1];
            src_data[k]   = stage_data[k-1];
            src_amount[k] = stage_amount[k-1];
            src_op[k]     = stage_op[k-1];
            src_tag[k]    = stage_tag[k-1];
            src_sign[k]   = stage_sign[k-1];
        end
        for (int k = 0; k < AW; k++) begin
            next_data[k] = src_amount[k][k] ? shift_step(src_data[k], src_op[k], src_sign[k], k)
                                            : src_data[k];
            // The last layer undoes the input reversal so SLL leaves in natural order.
            if (k == AW - 1 && src_op[k] == OP_SLL) next_data[k] = bit_reverse(next_data[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= '0;
            for (int k = 0; k < AW; k++) begin
                stage_data[k]   <= '0;
                stage_amount[k] <= '0;
                stage_op[k]     <= '0;
                stage_tag[k]    <= '0;
                stage_sign[k]   <= 1'b0;
            end
        end else begin
            for (int k = 0; k < AW; k++) begin
                if (flush)        stage_valid[k] <= 1'b0;
                else if (load[k]) stage_valid[k] <= src_valid[k];
                if (load[k]) begin
                    stage_data[k]   <= next_data[k];
                    stage_amount[k] <= src_amount[k];
                    stage_op[k]     <= src_op[k];
                    stage_tag[k]    <= src_tag[k];
                    stage_sign[k]   <= src_sign[k];
                end
            end
        end
    end

    assign out_valid = stage_valid[AW-1];
    assign out_data  = stage_data[AW-1];
    assign out_tag   = stage_tag[AW-1];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed bench for pipelined_barrel_shifter at WIDTH=32: ops, latency, backpressure,
// bubbles, flush and asynchronous reset.
module tb_pipelined_barrel_shifter;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_amount;
    logic [1:0]  in_op;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_tag;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  t;
    } exp_t;

    pipelined_barrel_shifter #(.WIDTH(32), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_amount(in_amount), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference shift written with native operators.
    function automatic logic [31:0] model_shift(input logic [31:0] d, input logic [4:0] a,
                                                input logic [1:0] op);
        case (op)
            2'b00:   return d << a;
            2'b01:   return d >> a;
            2'b10:   return $signed(d) >>> a;
            default: return (a == 5'd0) ? d : ((d >> a) | (d << (32 - int'(a))));
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] d, input logic [4:0] a,
                          input logic [1:0] op, input logic [3:0] t);
        in_valid  = v;
        in_data   = d;
        in_amount = a;
        in_op     = op;
        in_tag    = t;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        set_in(1'b0, 32'h0, 5'd0, 2'b00, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        checks++; if (out_tag !== 4'h0) begin failures++; $display("FAIL reset_out_tag got=%h want=0", out_tag); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_basic_ops();
        logic [31:0] din [4] = '{32'h0000_0001, 32'h8000_0000, 32'h8000_0000, 32'h1234_5678};
        logic [4:0]  amt [4] = '{5'd31, 5'd31, 5'd4, 5'd8};
        logic [31:0] exp [4] = '{32'h8000_0000, 32'h0000_0001, 32'hF800_0000, 32'h7812_3456};
        out_ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, din[i], amt[i], 2'(i), 4'(i + 1));
            #1;
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_in_ready[%0d] got=%b want=1", i, in_ready); end
            tick();
        end
        set_in(1'b0, 32'h0, 5'd0, 2'b00, 4'h0);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b want=0", out_valid); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp[i] || out_tag !== 4'(i + 1)) begin
                failures++;
                $display("FAIL basic_result[%0d] got v=%b d=%h t=%h want v=1 d=%h t=%h",
                         i, out_valid, out_data, out_tag, exp[i], 4'(i + 1));
            end
        end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_drain_valid got=%b want=0", out_valid); end
    endtask

    task automatic test_amount_zero();
        logic [31:0] din [5] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h7FFF_FFFF};
        logic [4:0]  amt [5] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd31};
        logic [1:0]  ops [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10};
        logic [31:0] exp [5] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000};
        int idx;
        int budget;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, din[i], amt[i], ops[i], 4'(i + 8));
            tick();
        end
        set_in(1'b0, 32'h0, 5'd0, 2'b00, 4'h0);
        idx = 0;
        budget = 0;
        while (idx < 5 && budget < 20) begin
            if (out_valid) begin
                checks++;
                if (out_data !== exp[idx] || out_tag !== 4'(idx + 8)) begin
                    failures++;
                    $display("FAIL zero_amt[%0d] got d=%h t=%h want d=%h t=%h",
                             idx, out_data, out_tag, exp[idx], 4'(idx + 8));
                end
                idx++;
            end
            tick();
            budget++;
        end
        checks++; if (idx != 5) begin failures++; $display("FAIL zero_amt_count got=%0d want=5", idx); end
    endtask

    task automatic test_backpressure();
        logic [31:0] din [6];
        logic [4:0]  amt [6];
        logic [1:0]  ops [6];
        logic [31:0] exp [6];
        int nxt;
        int accepts;
        int idx;
        int budget;
        logic took;
        for (int i = 0; i < 6; i++) begin
            din[i] = 32'h9137_5AC1 ^ (32'h0101_0101 * 32'(i));
            amt[i] = 5'(3 * i + 1);
            ops[i] = 2'(i);
            exp[i] = model_shift(din[i], amt[i], ops[i]);
        end
        out_ready = 1'b0;
        nxt = 0;
        accepts = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            set_in(1'b1, din[nxt], amt[nxt], ops[nxt], 4'(nxt));
            #1;
            took = in_ready;
            if (took) accepts++;
            if (cyc >= 5) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== exp[0] || out_tag !== 4'd0) begin
                    failures++;
                    $display("FAIL bp_stable[%0d] got v=%b d=%h t=%h want v=1 d=%h t=0",
                             cyc, out_valid, out_data, out_tag, exp[0]);
                end
            end
            tick();
            if (took) nxt++;
        end
        checks++; if (accepts != 5) begin failures++; $display("FAIL bp_accepts got=%0d want=5", accepts); end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_same_cycle got in_ready=%b out_valid=%b want 1 1", in_ready, out_valid);
        end
        tick();
        out_ready = 1'b0;
        set_in(1'b0, 32'h0, 5'd0, 2'b00, 4'h0);
        #1;
        checks++; if (out_data !== exp[1] || out_tag !== 4'd1) begin failures++; $display("FAIL bp_retire got d=%h t=%h want d=%h t=1", out_data, out_tag, exp[1]); end
        out_ready = 1'b1;
        idx = 1;
        budget = 0;
        while (idx < 6 && budget < 20) begin
            if (out_valid) begin
                checks++;
                if (out_data !== exp[idx] || out_tag !== 4'(idx)) begin
                    failures++;
                    $display("FAIL bp_drain[%0d] got d=%h t=%h want d=%h t=%h",
                             idx, out_data, out_tag, exp[idx], 4'(idx));
                end
                idx++;
            end
            tick();
            budget++;
        end
        checks++; if (idx != 6) begin failures++; $display("FAIL bp_drain_count got=%0d want=6", idx); end
    endtask

    task automatic test_bubbles();
        exp_t sb[$];
        exp_t e;
        int sent;
        int got;
        int budget;
        logic [31:0] d;
        logic [4:0]  a;
        logic [1:0]  op;
        sent = 0;
        got = 0;
        budget = 0;
        d = $urandom;
        a = 5'($urandom_range(0, 31));
        op = 2'($urandom_range(0, 3));
        while ((sent < 20 || sb.size() != 0) && budget < 600) begin
            set_in((sent < 20) ? 1'($urandom_range(0, 1)) : 1'b0, d, a, op, 4'(sent));
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (in_valid && in_ready) begin
                e.d = model_shift(d, a, op);
                e.t = 4'(sent);
                sb.push_back(e);
                sent++;
                d = $urandom;
                a = 5'($urandom_range(0, 31));
                op = 2'($urandom_range(0, 3));
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL bubble_spurious got d=%h t=%h want no result", out_data, out_tag);
                end else begin
                    e = sb.pop_front();
                    if (out_data !== e.d || out_tag !== e.t) begin
                        failures++;
                        $display("FAIL bubble_result[%0d] got d=%h t=%h want d=%h t=%h",
                                 got, out_data, out_tag, e.d, e.t);
                    end
                end
                got++;
            end
            tick();
            budget++;
        end
        set_in(1'b0, 32'h0, 5'd0, 2'b00, 4'h0);
        checks++; if (got != 20 || sent != 20) begin failures++; $display("FAIL bubble_count got=%0d sent=%0d want 20 20", got, sent); end
    endtask

    task automatic test_flush();
        int seen;
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 32'hA5A5_0000 + 32'(i), 5'd1, 2'b01, 4'(4 + i));
            tick();
        end
        set_in(1'b1, 32'hFFFF_0000, 5'd2, 2'b10, 4'd7);
        flush = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b want=0", in_ready); end
        tick();
        flush = 1'b0;
        set_in(1'b0, 32'h0, 5'd0, 2'b00, 4'h0);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%b want=0", out_valid); end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) seen++;
            tick();
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL flush_ghost got=%0d results want=0", seen); end
        set_in(1'b1, 32'h0000_00F0, 5'd4, 2'b00, 4'd9);
        tick();
        set_in(1'b0, 32'h0, 5'd0, 2'b00, 4'h0);
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        checks++;
        if (lat != 5 || out_data !== 32'h0000_0F00 || out_tag !== 4'd9) begin
            failures++;
            $display("FAIL flush_recover got lat=%0d d=%h t=%h want lat=5 d=00000f00 t=9", lat, out_data, out_tag);
        end
        tick();
    endtask

    task automatic test_async_reset();
        int budget;
        int seen;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 32'hC0DE_0000 + 32'(i), 5'(i), 2'b11, 4'(12 + i));
            tick();
        end
        set_in(1'b0, 32'h0, 5'd0, 2'b00, 4'h0);
        budget = 0;
        while (!out_valid && budget < 20) begin
            tick();
            budget++;
        end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL areset_pre_valid got=%b want=1", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_tag !== 4'h0) begin
            failures++;
            $display("FAIL areset_immediate got v=%b d=%h t=%h want 0 0 0", out_valid, out_data, out_tag);
        end
        #3;
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL areset_in_ready got=%b want=1", in_ready); end
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL areset_ghost got=%0d results want=0", seen); end
    endtask

    initial begin
        test_reset();
        test_basic_ops();
        test_amount_zero();
        test_backpressure();
        test_bubbles();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
